// File: rtl/multi_line_buffer_pkg.sv
// Shared definitions for multi_line_buffer: FSM state encoding and the
// runtime line-width clamp.
package multi_line_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // A width of zero or one beyond the physical line maps to the full line.
  function automatic int unsigned clamp_width(input int unsigned w,
                                              input int unsigned line_w);
    return ((w == 0) || (w > line_w)) ? line_w : w;
  endfunction

endpackage

// File: rtl/multi_line_buffer_line_mem.sv
// One stored image line: LINE_W x DW, asynchronous read, synchronous write.
module line_mem #(
  parameter int DW     = 24,
  parameter int LINE_W = 960,
  parameter int AW     = $clog2(LINE_W)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  // NOTE: line storage has no reset; stale rows are masked by the row count.
  logic [DW-1:0] mem_q [LINE_W];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/multi_line_buffer.sv
// Column-indexed multi-line buffer emitting an NTAP-row vertical pixel column
// per accepted pixel. Define MULTI_LINE_BUFFER_PRIME_EN for top-edge replication.
module multi_line_buffer
  import multi_line_buffer_pkg::*;
#(
  parameter int DW     = 24,
  parameter int LINE_W = 960,
  parameter int NTAP   = 4,
  parameter int AW     = $clog2(LINE_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [AW:0]        cfg_width,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DW-1:0]      s_data,
  input  logic               s_sof,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [NTAP*DW-1:0] m_data,
  output logic [AW-1:0]      m_col,
  output logic               m_eol
);

  localparam int RW = $clog2(NTAP);
  localparam logic [RW-1:0] ROWS_FULL = RW'(NTAP - 1);

  state_e              state_q, state_d;
  logic [AW-1:0]       col_q, col_d, col_use;
  logic [RW-1:0]       rows_q, rows_d, rows_use;
  logic [AW:0]         width_q, w_use;
  logic                accept, proc, produce, eol;
  logic [DW-1:0]       rd [NTAP-1];
  logic [NTAP*DW-1:0]  taps;

  logic                m_valid_q;
  logic [NTAP*DW-1:0]  m_data_q;
  logic [AW-1:0]       m_col_q;
  logic                m_eol_q;

  assign s_ready = !m_valid_q || m_ready;

  // NOTE: every always_comb output gets a default up front so no latch is inferred.
  always_comb begin
    accept   = s_valid && s_ready && !rst;
    proc     = accept && (s_sof || (state_q != ST_IDLE));
    w_use    = width_q;
    col_use  = col_q;
    rows_use = rows_q;
    if (s_sof) begin
      w_use    = (AW+1)'(clamp_width(32'(cfg_width), LINE_W));
      col_use  = '0;
      rows_use = '0;
    end

    eol    = ({1'b0, col_use} == (w_use - 1'b1));
    col_d  = eol ? '0 : col_use + 1'b1;
    rows_d = rows_use;
    if (eol && (rows_use != ROWS_FULL)) rows_d = rows_use + 1'b1;
    state_d = (rows_d == ROWS_FULL) ? ST_RUN : ST_FILL;

`ifdef MULTI_LINE_BUFFER_PRIME_EN
    produce = proc;
`else
    produce = proc && (rows_use == ROWS_FULL);
`endif

    taps = '0;
    for (int k = 0; k < NTAP; k++) begin
      int sel;
      sel = k;
`ifdef MULTI_LINE_BUFFER_PRIME_EN
      // Rows not yet filled replicate the oldest valid row.
      if (k > int'(rows_use)) sel = int'(rows_use);
`endif
      taps[k*DW +: DW] = (sel == 0) ? s_data : rd[sel-1];
    end
  end

  for (genvar k = 0; k < NTAP - 1; k++) begin : g_mem
    logic [DW-1:0] wdata;
    if (k == 0) begin : g_first
      assign wdata = s_data;
    end else begin : g_next
      assign wdata = rd[k-1];
    end
    line_mem #(.DW(DW), .LINE_W(LINE_W), .AW(AW)) u_line_mem (
      .clk     (clk),
      .we_i    (proc),
      .addr_i  (col_use),
      .wdata_i (wdata),
      .rdata_o (rd[k])
    );
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      col_q     <= '0;
      rows_q    <= '0;
      width_q   <= (AW+1)'(LINE_W);
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_col_q   <= '0;
      m_eol_q   <= 1'b0;
    end else begin
      if (proc) begin
        state_q <= state_d;
        col_q   <= col_d;
        rows_q  <= rows_d;
        if (s_sof) width_q <= w_use;
      end
      if (produce) begin
        m_valid_q <= 1'b1;
        m_data_q  <= taps;
        m_col_q   <= col_use;
        m_eol_q   <= eol;
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_col   = m_col_q;
  assign m_eol   = m_eol_q;

endmodule
